ahblite_gpio_slave: RTL and testbench



---
 rtl/ahblite_gpio_pkg.sv | 30 +++
 rtl/gpio_in_sync.sv | 32 +++
 rtl/ahblite_gpio_slave.sv | 123 ++++++++++++
 tb/tb_ahblite_gpio_slave.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahblite_gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO responder: register offsets,
// HTRANS encodings and the byte-lane mask helper.
package ahblite_gpio_pkg;

  localparam logic [2:0] GPIO_DATA_OFS    = 3'd0;
  localparam logic [2:0] GPIO_OUTEN_OFS   = 3'd1;
  localparam logic [2:0] GPIO_INTEN_OFS   = 3'd2;
  localparam logic [2:0] GPIO_INTSTAT_OFS = 3'd3;
  localparam logic [2:0] GPIO_DOUT_OFS    = 3'd4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Sizes above word are folded into the full four-lane mask.
  function automatic logic [3:0] lane_mask(input logic [2:0] i_size,
                                           input logic [1:0] i_addr);
    logic [3:0] w_mask;
    case (i_size)
      3'd0:    w_mask = 4'b0001 << i_addr;
      3'd1:    w_mask = i_addr[1] ? 4'b1100 : 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    return w_mask;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for the GPIO pins followed by a rising-edge
// detector on the synchronized value.
module gpio_in_sync #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_sync = r_sync2;
  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/ahblite_gpio_slave.sv
// Zero-wait-state AHB-Lite responder exposing the GPIO register file
// (output data, output enable, interrupt enable, W1C interrupt status).
module ahblite_gpio_slave
  import ahblite_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  input  logic [GPIO_WIDTH-1:0] GPIO_IN,
  output logic [GPIO_WIDTH-1:0] GPIO_OUT,
  output logic [GPIO_WIDTH-1:0] GPIO_OE,
  output logic                  GPIO_IRQ
);

  logic                  w_accept;
  logic                  r_valid;
  logic                  r_write;
  logic [2:0]            r_ofs;
  logic [3:0]            r_mask;

  logic [31:0]           w_bmask;
  logic [GPIO_WIDTH-1:0] w_lane;
  logic [GPIO_WIDTH-1:0] w_wdata;
  logic                  w_wr;

  logic [GPIO_WIDTH-1:0] r_dout;
  logic [GPIO_WIDTH-1:0] r_outen;
  logic [GPIO_WIDTH-1:0] r_inten;
  logic [GPIO_WIDTH-1:0] r_intstat;

  logic [GPIO_WIDTH-1:0] w_sync;
  logic [GPIO_WIDTH-1:0] w_rise;
  logic [GPIO_WIDTH-1:0] w_clear;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  gpio_in_sync #(
    .WIDTH (GPIO_WIDTH)
  ) u_in_sync (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_in    (GPIO_IN),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign w_accept = HSEL & HTRANS[1] & HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_ofs   <= '0;
      r_mask  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_write <= HWRITE;
        r_ofs   <= HADDR[4:2];
        r_mask  <= lane_mask(HSIZE, HADDR[1:0]);
      end
    end
  end

  assign w_bmask = {{8{r_mask[3]}}, {8{r_mask[2]}}, {8{r_mask[1]}}, {8{r_mask[0]}}};
  assign w_lane  = w_bmask[GPIO_WIDTH-1:0];
  assign w_wdata = HWDATA[GPIO_WIDTH-1:0];
  assign w_wr    = r_valid & r_write;
  assign w_clear = (w_wr && r_ofs == GPIO_INTSTAT_OFS) ? (w_wdata & w_lane) : '0;

  // New rises are OR-ed in after the W1C clear so a coincident set wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dout    <= '0;
      r_outen   <= '0;
      r_inten   <= '0;
      r_intstat <= '0;
    end else begin
      if (w_wr && r_ofs == GPIO_DATA_OFS)
        r_dout <= (r_dout & ~w_lane) | (w_wdata & w_lane);
      if (w_wr && r_ofs == GPIO_OUTEN_OFS)
        r_outen <= (r_outen & ~w_lane) | (w_wdata & w_lane);
      if (w_wr && r_ofs == GPIO_INTEN_OFS)
        r_inten <= (r_inten & ~w_lane) | (w_wdata & w_lane);
      r_intstat <= (r_intstat & ~w_clear) | (w_rise & r_inten);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (r_valid && !r_write) begin
      case (r_ofs)
        GPIO_DATA_OFS:    w_rdata = 32'(w_sync);
        GPIO_OUTEN_OFS:   w_rdata = 32'(r_outen);
        GPIO_INTEN_OFS:   w_rdata = 32'(r_inten);
        GPIO_INTSTAT_OFS: w_rdata = 32'(r_intstat);
        GPIO_DOUT_OFS:    w_rdata = 32'(r_dout);
        default:          w_rdata = '0;
      endcase
    end
  end

  assign HRDATA    = w_rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIO_OUT  = r_dout;
  assign GPIO_OE   = r_outen;
  assign GPIO_IRQ  = |r_intstat;

  assign w_unused = &{1'b0, HADDR[31:5], HTRANS[0], HWDATA, w_bmask};

endmodule

// File: tb/tb_ahblite_gpio_slave.sv
// Directed bench for ahblite_gpio_slave: a table of single transfers
// followed by hand-timed sequences for pipelining, interrupts and reset.
module tb_ahblite_gpio_slave;

  localparam int W = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [W-1:0]  GPIO_IN;
  logic [W-1:0]  GPIO_OUT;
  logic [W-1:0]  GPIO_OE;
  logic          GPIO_IRQ;

  int total = 0;
  int bad   = 0;

  ahblite_gpio_slave #(.GPIO_WIDTH(W)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .GPIO_IN   (GPIO_IN),
    .GPIO_OUT  (GPIO_OUT),
    .GPIO_OE   (GPIO_OE),
    .GPIO_IRQ  (GPIO_IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        ready;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic [15:0] expOut;
    logic [15:0] expOe;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic ready,
                               input logic write, input logic [31:0] addr,
                               input logic [2:0] size);
    HSEL   = sel;
    HTRANS = trans;
    HREADY = ready;
    HWRITE = write;
    HADDR  = addr;
    HSIZE  = size;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 3'd0);
  endtask

  // One isolated transfer; returns HRDATA sampled inside the data phase.
  task automatic doTransfer(input logic write, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    applyStimulus(1'b1, 2'b10, 1'b1, write, addr, size);
    tick();
    HWDATA = wdata;
    idleBus();
    rdata = HRDATA;
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    HRESETn = 1'b0;
    GPIO_IN = '0;
    HWDATA  = '0;
    idleBus();
    #2;
    checkOutput("reset hreadyout/hresp", {30'd0, HREADYOUT, HRESP}, 32'h2);
    repeat (3) tick();
    HRESETn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 32'(i * 4), 3'd2, 32'h0, 32'h0, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h00, 3'd2, 32'h0000A5A5, 32'h0, 16'hA5A5, 16'h0000});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 32'h0000A5A5, 16'hA5A5, 16'h0000});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 32'h00, 3'd2, 32'h0, 32'h0, 16'hA5A5, 16'h0000});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h06, 3'd1, 32'h12340000, 32'h0, 16'hA5A5, 16'h0000});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 32'h04, 3'd2, 32'h0, 32'h0, 16'hA5A5, 16'h0000});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h04, 3'd0, 32'h0000003C, 32'h0, 16'hA5A5, 16'h003C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h05, 3'd0, 32'h00005A00, 32'h0, 16'hA5A5, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 32'h04, 3'd2, 32'h0, 32'h00005A3C, 16'hA5A5, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h10, 3'd2, 32'h0000FFFF, 32'h0, 16'hA5A5, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h14, 3'd2, 32'hFFFFFFFF, 32'h0, 16'hA5A5, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 32'h1C, 3'd2, 32'h0, 32'h0, 16'hA5A5, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h00, 3'd2, 32'hFFFFFFFF, 32'h0, 16'hFFFF, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 32'h10, 3'd2, 32'h0, 32'h0000FFFF, 16'hFFFF, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h01, 3'd0, 32'h00001200, 32'h0, 16'h12FF, 16'h5A3C});
    vecs.push_back('{1'b0, 2'b10, 1'b1, 1'b1, 32'h00, 3'd2, 32'h00001111, 32'h0, 16'h12FF, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b00, 1'b1, 1'b1, 32'h00, 3'd2, 32'h00001111, 32'h0, 16'h12FF, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b01, 1'b1, 1'b1, 32'h00, 3'd2, 32'h00001111, 32'h0, 16'h12FF, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 1'b1, 32'h00, 3'd2, 32'h00001111, 32'h0, 16'h12FF, 16'h5A3C});
    vecs.push_back('{1'b0, 2'b10, 1'b1, 1'b0, 32'h04, 3'd2, 32'h0, 32'h0, 16'h12FF, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b1, 32'h08, 3'd3, 32'h00000001, 32'h0, 16'h12FF, 16'h5A3C});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 1'b0, 32'h08, 3'd2, 32'h0, 32'h00000001, 16'h12FF, 16'h5A3C});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].trans, vecs[i].ready, vecs[i].write,
                    vecs[i].addr, vecs[i].size);
      tick();
      HWDATA = vecs[i].wdata;
      idleBus();
      checkOutput($sformatf("vec%0d hrdata", i), HRDATA, vecs[i].expRdata);
      tick();
      checkOutput($sformatf("vec%0d gpio_out", i), 32'(GPIO_OUT), 32'(vecs[i].expOut));
      checkOutput($sformatf("vec%0d gpio_oe", i), 32'(GPIO_OE), 32'(vecs[i].expOe));
      checkOutput($sformatf("vec%0d irq/ready/resp", i),
                  {29'd0, GPIO_IRQ, HREADYOUT, HRESP}, 32'h2);
    end

    // Write DATA then read DOUT back-to-back.
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 32'h00, 3'd2);
    tick();
    HWDATA = 32'h0000C3C3;
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 32'h10, 3'd2);
    checkOutput("b2b gpio_out before commit", 32'(GPIO_OUT), 32'h000012FF);
    tick();
    idleBus();
    checkOutput("b2b dout readback", HRDATA, 32'h0000C3C3);
    checkOutput("b2b gpio_out after commit", 32'(GPIO_OUT), 32'h0000C3C3);
    tick();

    // Rising edge on pin 0 with INTEN[0]=1.
    GPIO_IN = 16'h0001;
    tick();
    tick();
    checkOutput("irq low after 2 edges", 32'(GPIO_IRQ), 32'h0);
    tick();
    checkOutput("irq high after 3 edges", 32'(GPIO_IRQ), 32'h1);
    doTransfer(1'b0, 32'h0C, 3'd2, 32'h0, rd);
    checkOutput("intstatus after rise", rd, 32'h1);
    doTransfer(1'b0, 32'h00, 3'd2, 32'h0, rd);
    checkOutput("data read sync input", rd, 32'h1);
    doTransfer(1'b1, 32'h0C, 3'd2, 32'h1, rd);
    checkOutput("irq after w1c", 32'(GPIO_IRQ), 32'h0);
    GPIO_IN = 16'h0003;
    repeat (4) tick();
    checkOutput("irq masked pin1", 32'(GPIO_IRQ), 32'h0);
    doTransfer(1'b0, 32'h0C, 3'd2, 32'h0, rd);
    checkOutput("intstatus masked pin1", rd, 32'h0);

    // W1C of bit 0 committing on the same edge that sets bit 0.
    GPIO_IN = 16'h0002;
    repeat (3) tick();
    GPIO_IN = 16'h0003;
    tick();
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 32'h0C, 3'd2);
    tick();
    HWDATA = 32'h1;
    idleBus();
    checkOutput("collision irq before edge", 32'(GPIO_IRQ), 32'h0);
    tick();
    checkOutput("collision irq set wins", 32'(GPIO_IRQ), 32'h1);
    doTransfer(1'b0, 32'h0C, 3'd2, 32'h0, rd);
    checkOutput("collision intstatus", rd, 32'h1);

    // Reset during the data phase of an OUTEN write.
    doTransfer(1'b1, 32'h04, 3'd2, 32'h00000000, rd);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 32'h04, 3'd2);
    tick();
    HWDATA = 32'h0000FFFF;
    idleBus();
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("in reset gpio_out", 32'(GPIO_OUT), 32'h0);
    checkOutput("in reset gpio_oe", 32'(GPIO_OE), 32'h0);
    checkOutput("in reset irq/ready/resp", {29'd0, GPIO_IRQ, HREADYOUT, HRESP}, 32'h2);
    checkOutput("in reset hrdata", HRDATA, 32'h0);
    tick();
    tick();
    HRESETn = 1'b1;
    tick();
    checkOutput("after reset gpio_oe", 32'(GPIO_OE), 32'h0);
    doTransfer(1'b0, 32'h04, 3'd2, 32'h0, rd);
    checkOutput("after reset outen read", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
